// File: rtl/ifetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ifetch_stage_pkg
//  Purpose : Shared types and constants for the instruction-fetch stage:
//            FSM state encoding, instruction word width, PC increment,
//            queue entry layout and a word-alignment helper.
//  Revision: 1.0 - initial release
// ============================================================================
package ifetch_stage_pkg;

   localparam int unsigned INST_W = 32;
   localparam logic [31:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INST_W-1:0] inst;
   } iq_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ifetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module  : ifetch_stage_if
//  Purpose : Instruction-memory request/acknowledge bus.
//  Ports   : imem_req   - fetch request (master -> slave)
//            imem_addr  - word-aligned fetch address (master -> slave)
//            imem_ack   - request completes this cycle (slave -> master)
//            imem_rdata - instruction word, valid with imem_ack
//  Revision: 1.0 - initial release
// ============================================================================
interface ifetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr,
                   input  imem_ack, input  imem_rdata);
   modport slave  (input  imem_req, input  imem_addr,
                   output imem_ack, output imem_rdata);
endinterface
`default_nettype wire

// File: rtl/ifetch_stage_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module  : fetch_queue
//  Purpose : Synchronous FIFO of {pc, inst} entries between fetch and decode.
//  Ports   : clk, clrn (async active-low clear)
//            push/push_data - write an entry
//            pop            - retire the head entry
//            flush          - empty the queue (wins over push/pop)
//            head           - oldest entry (meaningful only when !empty)
//            full, empty, count
//  Revision: 1.0 - initial release
// ============================================================================
module fetch_queue
   import ifetch_stage_pkg::*;
#(
   parameter int unsigned IQ_DEPTH = 2
) (
   input  wire                              clk,
   input  wire                              clrn,
   input  wire                              push,
   input  iq_entry_t                        push_data,
   input  wire                              pop,
   input  wire                              flush,
   output iq_entry_t                        head,
   output logic                             full,
   output logic                             empty,
   output logic [$clog2(IQ_DEPTH):0]        count
);
   localparam int unsigned PW = $clog2(IQ_DEPTH);
   localparam int unsigned CW = PW + 1;

   iq_entry_t         mem_q [IQ_DEPTH];
   iq_entry_t         mem_d [IQ_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q,  count_d;
   logic              push_ok, pop_ok;

   assign full    = (count_q == CW'(IQ_DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);   // power-of-2 depth: natural wrap
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         count_d = count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         for (int i = 0; i < int'(IQ_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
//  Module  : ifetch_stage
//  Purpose : Instruction-fetch stage. Owns the fetch PC, runs one outstanding
//            req/ack transaction to instruction memory, buffers words in a
//            small queue for decode and discards fetches on redirect.
//  Ports   : clk, clrn (async active-low reset)
//            imem        - instruction-memory bus (master side)
//            redirect, redirect_pc - branch/jump retarget
//            stall       - decode holds the head entry
//            id_valid, id_inst, id_pc, id_pc4 - head of the queue
//  Revision: 1.0 - initial release
// ============================================================================
module ifetch_stage
   import ifetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned IQ_DEPTH = 2
) (
   input  wire                 clk,
   input  wire                 clrn,
   ifetch_stage_if.master      imem,
   input  wire                 redirect,
   input  wire  [31:0]         redirect_pc,
   input  wire                 stall,
   output logic                id_valid,
   output logic [INST_W-1:0]   id_inst,
   output logic [31:0]         id_pc,
   output logic [31:0]         id_pc4
);
   localparam int unsigned CW = $clog2(IQ_DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   drop_addr_q, drop_addr_d;   // address still owed an ack in DROP

   logic          iq_push, iq_pop, iq_full, iq_empty;
   logic [CW-1:0] iq_count;
   iq_entry_t     iq_head, iq_wdata;

   assign iq_wdata = '{pc: fetch_pc_q, inst: imem.imem_rdata};
   assign iq_pop   = id_valid & ~stall;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;
      iq_push     = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // A redirect flushes the queue, so a slot is guaranteed free.
            if (redirect || (iq_count < CW'(IQ_DEPTH))) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            if (redirect) begin
               state_d     = imem.imem_ack ? ST_IDLE : ST_DROP;
               drop_addr_d = fetch_pc_q;
            end else if (imem.imem_ack) begin
               iq_push    = ~iq_full;
               fetch_pc_d = fetch_pc_q + PC_INC;
               state_d    = ST_IDLE;
            end
         end
         ST_DROP: begin
            if (imem.imem_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (redirect) begin
         fetch_pc_d = align_word(redirect_pc);
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= ST_IDLE;
         fetch_pc_q  <= RESET_PC;
         drop_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

   assign imem.imem_req  = (state_q != ST_IDLE);
   assign imem.imem_addr = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;

   fetch_queue #(.IQ_DEPTH(IQ_DEPTH)) u_fetch_queue (
      .clk       (clk),
      .clrn      (clrn),
      .push      (iq_push),
      .push_data (iq_wdata),
      .pop       (iq_pop),
      .flush     (redirect),
      .head      (iq_head),
      .full      (iq_full),
      .empty     (iq_empty),
      .count     (iq_count)
   );

   // Empty queue presents zeros rather than stale storage.
   assign id_valid = ~iq_empty;
   assign id_inst  = iq_empty ? '0 : iq_head.inst;
   assign id_pc    = iq_empty ? '0 : iq_head.pc;
   assign id_pc4   = id_pc + PC_INC;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ifetch_stage
//  Purpose : Directed self-checking bench for ifetch_stage.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_ifetch_stage;
   logic        clk = 1'b0;
   logic        clrn, clrn2;
   logic        redirect, stall, redirect2, stall2;
   logic [31:0] redirect_pc, redirect_pc2;
   logic        id_valid, id_valid2;
   logic [31:0] id_inst, id_pc, id_pc4, id_inst2, id_pc2, id_pc42;

   int n_checks = 0;
   int n_fail   = 0;

   ifetch_stage_if imem1 ();
   ifetch_stage_if imem2 ();

   always #5 clk = ~clk;

   ifetch_stage #(.RESET_PC(32'h0000_0000), .IQ_DEPTH(2)) dut (
      .clk(clk), .clrn(clrn), .imem(imem1.master),
      .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
      .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4)
   );

   ifetch_stage #(.RESET_PC(32'hFFFF_FFFC), .IQ_DEPTH(2)) dut_wrap (
      .clk(clk), .clrn(clrn2), .imem(imem2.master),
      .redirect(redirect2), .redirect_pc(redirect_pc2), .stall(stall2),
      .id_valid(id_valid2), .id_inst(id_inst2), .id_pc(id_pc2), .id_pc4(id_pc42)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One fetch on dut: request visible now, ack in its second cycle,
   // returns just after the pushing edge.
   task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
      check_eq({tag, "_req"},  32'(imem1.imem_req), 32'd1);
      check_eq({tag, "_addr"}, imem1.imem_addr, addr);
      tick();
      check_eq({tag, "_addr_hold"}, imem1.imem_addr, addr);
      imem1.imem_ack   = 1'b1;
      imem1.imem_rdata = data;
      tick();
      imem1.imem_ack   = 1'b0;
      imem1.imem_rdata = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1);
   end

   initial begin
      clrn = 1'b0; clrn2 = 1'b0;
      redirect = 1'b0; redirect_pc = 32'h0; stall = 1'b0;
      redirect2 = 1'b0; redirect_pc2 = 32'h0; stall2 = 1'b0;
      imem1.imem_ack = 1'b0; imem1.imem_rdata = 32'h0;
      imem2.imem_ack = 1'b0; imem2.imem_rdata = 32'h0;
      tick(); tick();

      // Reset state
      check_eq("rst_req",      32'(imem1.imem_req), 32'd0);
      check_eq("rst_addr",     imem1.imem_addr, 32'h0);
      check_eq("rst_id_valid", 32'(id_valid), 32'd0);
      check_eq("rst_id_inst",  id_inst, 32'h0);
      check_eq("rst_id_pc",    id_pc, 32'h0);

      // In-order fetch
      clrn = 1'b1;
      tick();
      fetch("f0", 32'h0, 32'h1111_0000);
      check_eq("f0_valid", 32'(id_valid), 32'd1);
      check_eq("f0_pc",    id_pc,   32'h0);
      check_eq("f0_inst",  id_inst, 32'h1111_0000);
      check_eq("f0_pc4",   id_pc4,  32'h4);
      // ack while idle must not push anything
      imem1.imem_ack = 1'b1; imem1.imem_rdata = 32'hBAD0_BAD0;
      tick();
      imem1.imem_ack = 1'b0; imem1.imem_rdata = 32'h0;
      check_eq("idle_ack_valid", 32'(id_valid), 32'd0);
      fetch("f4", 32'h4, 32'h2222_0004);
      check_eq("f4_pc",   id_pc,   32'h4);
      check_eq("f4_inst", id_inst, 32'h2222_0004);
      check_eq("f4_pc4",  id_pc4,  32'h8);

      // Stall: head holds, queue fills, fetching stops
      stall = 1'b1;
      tick();
      check_eq("st_pc_hold", id_pc, 32'h4);
      fetch("f8", 32'h8, 32'h3333_0008);
      check_eq("st_pc_hold2", id_pc, 32'h4);
      tick();
      check_eq("full_req0", 32'(imem1.imem_req), 32'd0);
      tick();
      check_eq("full_req0b", 32'(imem1.imem_req), 32'd0);
      check_eq("full_inst",  id_inst, 32'h2222_0004);
      stall = 1'b0;
      tick();
      check_eq("rel_pc",   id_pc,   32'h8);
      check_eq("rel_inst", id_inst, 32'h3333_0008);
      check_eq("rel_req",  32'(imem1.imem_req), 32'd0);
      tick();
      check_eq("rel_empty", 32'(id_valid), 32'd0);
      check_eq("rel_req1",  32'(imem1.imem_req), 32'd1);
      check_eq("rel_addr",  imem1.imem_addr, 32'hC);

      // Redirect during REQ without ack -> DROP keeps the old address
      redirect = 1'b1; redirect_pc = 32'h100;
      tick();
      redirect = 1'b0;
      check_eq("drop_req",  32'(imem1.imem_req), 32'd1);
      check_eq("drop_addr", imem1.imem_addr, 32'hC);
      imem1.imem_ack = 1'b1; imem1.imem_rdata = 32'hDEAD_000C;
      tick();
      imem1.imem_ack = 1'b0; imem1.imem_rdata = 32'h0;
      check_eq("drop_disc_valid", 32'(id_valid), 32'd0);
      check_eq("drop_disc_req",   32'(imem1.imem_req), 32'd0);
      tick();
      stall = 1'b1;
      fetch("f100", 32'h100, 32'h4444_0100);
      check_eq("f100_pc", id_pc, 32'h100);

      // Redirect to unaligned target in the same cycle as ack
      tick();
      check_eq("f104_addr", imem1.imem_addr, 32'h104);
      tick();
      imem1.imem_ack = 1'b1; imem1.imem_rdata = 32'hDEAD_0104;
      redirect = 1'b1; redirect_pc = 32'h203;
      tick();
      imem1.imem_ack = 1'b0; imem1.imem_rdata = 32'h0; redirect = 1'b0;
      check_eq("rdack_valid", 32'(id_valid), 32'd0);
      check_eq("rdack_req",   32'(imem1.imem_req), 32'd0);
      tick();
      fetch("f200", 32'h200, 32'h5555_0200);
      check_eq("f200_pc",   id_pc,   32'h200);
      check_eq("f200_inst", id_inst, 32'h5555_0200);
      check_eq("f200_pc4",  id_pc4,  32'h204);

      // Async reset in the middle of a request
      tick();
      check_eq("mid_req", 32'(imem1.imem_req), 32'd1);
      clrn = 1'b0;
      #1;
      check_eq("arst_req",   32'(imem1.imem_req), 32'd0);
      check_eq("arst_valid", 32'(id_valid), 32'd0);
      check_eq("arst_addr",  imem1.imem_addr, 32'h0);
      check_eq("arst_pc",    id_pc, 32'h0);
      tick();
      clrn = 1'b1; stall = 1'b0;
      tick();
      check_eq("arst_rel_req",  32'(imem1.imem_req), 32'd1);
      check_eq("arst_rel_addr", imem1.imem_addr, 32'h0);

      // PC wrap from 32'hFFFF_FFFC
      clrn2 = 1'b1;
      tick();
      check_eq("wrap_addr0", imem2.imem_addr, 32'hFFFF_FFFC);
      tick();
      imem2.imem_ack = 1'b1; imem2.imem_rdata = 32'h6666_FFFC;
      tick();
      imem2.imem_ack = 1'b0; imem2.imem_rdata = 32'h0;
      check_eq("wrap_pc",  id_pc2,  32'hFFFF_FFFC);
      check_eq("wrap_pc4", id_pc42, 32'h0);
      check_eq("wrap_inst", id_inst2, 32'h6666_FFFC);
      tick();
      check_eq("wrap_req1",  32'(imem2.imem_req), 32'd1);
      check_eq("wrap_addr1", imem2.imem_addr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
